// File: rtl/hv_ramp_sched.sv
// hv_ramp_sched: slews 32 applied HV codes toward their targets and requests one DAC frame per ramp step.
// Define HV_KILL_EN to add the hv_kill emergency ramp-down input.
module hv_ramp_sched #(
  parameter logic [9:0] STEP         = 10'd8,
  parameter int         RAMP_DIV     = 1000,
  parameter int         FRAME_CYCLES = 200
) (
  input  logic         clkin,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [4:0]   wr_addr,
  input  logic [9:0]   wr_data,
`ifdef HV_KILL_EN
  input  logic         hv_kill,
`endif
  output logic         hv_update,
  output logic [319:0] hv_reg_dout,
  output logic         busy,
  output logic         at_target
);

  localparam logic [1:0]  ST_IDLE    = 2'd0;
  localparam logic [1:0]  ST_SCAN    = 2'd1;
  localparam logic [1:0]  ST_ISSUE   = 2'd2;
  localparam logic [1:0]  ST_WAIT    = 2'd3;
  localparam logic [15:0] DIV_LAST   = 16'(RAMP_DIV - 1);
  localparam logic [15:0] FRAME_LAST = 16'(FRAME_CYCLES - 1);
  localparam logic [10:0] STEP_EXT   = {1'b0, STEP};

  logic [319:0] tgt_flat;
  logic [31:0]  eq_w;
  logic [1:0]   state_reg, state_next;
  logic [4:0]   ch_reg;
  logic         chg_reg;
  logic [15:0]  frame_cnt_reg;
  logic [15:0]  div_cnt_reg;
  logic         pending_reg;
  logic         tick, kill_w, pending_eff, start_scan, scan_chg;
  logic [8:0]   sel_base;
  logic [10:0]  cur_sel, tgt_sel;
  logic [9:0]   step_next;

`ifdef HV_KILL_EN
  assign kill_w = hv_kill;
`else
  assign kill_w = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_ch
      logic [9:0] tgt_reg;
      logic [9:0] cur_reg;

      always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
          tgt_reg <= '0;
        end else if (kill_w) begin
          tgt_reg <= '0;
        end else if (wr_en && (wr_addr == 5'(gi))) begin
          tgt_reg <= wr_data;
        end
      end

      always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
          cur_reg <= '0;
        end else if ((state_reg == ST_SCAN) && (ch_reg == 5'(gi))) begin
          cur_reg <= step_next;
        end
      end

      assign eq_w[gi]                = (cur_reg == tgt_reg);
      assign tgt_flat[10*gi +: 10]    = tgt_reg;
      assign hv_reg_dout[10*gi +: 10] = cur_reg;
    end
  endgenerate

  assign at_target = &eq_w;
  assign hv_update = (state_reg == ST_ISSUE);
  assign busy      = (state_reg != ST_IDLE);

  // Step the channel under scan; distances are compared first so the result never crosses the target.
  assign sel_base = 9'(ch_reg) * 9'd10;
  always_comb begin
    cur_sel   = {1'b0, hv_reg_dout[sel_base +: 10]};
    tgt_sel   = {1'b0, tgt_flat[sel_base +: 10]};
    step_next = cur_sel[9:0];
    if (cur_sel < tgt_sel) begin
      step_next = ((tgt_sel - cur_sel) > STEP_EXT) ? 10'(cur_sel + STEP_EXT) : tgt_sel[9:0];
    end else if (cur_sel > tgt_sel) begin
      step_next = ((cur_sel - tgt_sel) > STEP_EXT) ? 10'(cur_sel - STEP_EXT) : tgt_sel[9:0];
    end
  end

  assign scan_chg = (state_reg == ST_SCAN) && (step_next != cur_sel[9:0]);

  assign tick        = (div_cnt_reg == DIV_LAST);
  assign pending_eff = pending_reg | kill_w;
  assign start_scan  = (state_reg == ST_IDLE) && pending_eff && !at_target;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      div_cnt_reg <= '0;
    end else if (tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 16'd1;
    end
  end

  // Ticks merge into one pending request; starting a scan consumes it.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      pending_reg <= 1'b0;
    end else if (start_scan) begin
      pending_reg <= 1'b0;
    end else if (tick) begin
      pending_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start_scan) state_next = ST_SCAN;
      ST_SCAN:  if (ch_reg == 5'd31) state_next = (chg_reg || scan_chg) ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (frame_cnt_reg == FRAME_LAST) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      ch_reg        <= '0;
      chg_reg       <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          ch_reg  <= '0;
          chg_reg <= 1'b0;
        end
        ST_SCAN: begin
          ch_reg  <= ch_reg + 5'd1;
          chg_reg <= chg_reg | scan_chg;
        end
        ST_ISSUE: frame_cnt_reg <= '0;
        ST_WAIT:  frame_cnt_reg <= frame_cnt_reg + 16'd1;
        default: ;
      endcase
    end
  end

endmodule
